// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path:
// opcodes, FSM states and datapath mux/ALU select codes.
package mips_ctrl_pkg;

   localparam logic [5:0] OPC_RTYPE = 6'h00;
   localparam logic [5:0] OPC_LW    = 6'h23;
   localparam logic [5:0] OPC_SW    = 6'h2B;
   localparam logic [5:0] OPC_BEQ   = 6'h04;
   localparam logic [5:0] OPC_BNE   = 6'h05;
   localparam logic [5:0] OPC_J     = 6'h02;
   localparam logic [5:0] OPC_ADDI  = 6'h08;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_REXEC  = 4'd7,
      S_RWB    = 4'd8,
      S_BRANCH = 4'd9,
      S_JUMP   = 4'd10,
      S_IEXEC  = 4'd11,
      S_IWB    = 4'd12,
      S_TRAP   = 4'd13
   } state_t;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG   = 2'd0;
   localparam logic [1:0] SRCB_FOUR  = 2'd1;
   localparam logic [1:0] SRCB_IMM   = 2'd2;
   localparam logic [1:0] SRCB_IMMSH = 2'd3;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       branch_ne;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       memto_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] aluop;
      logic [1:0] pc_source;
      logic       instr_done;
   } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// State-to-control-vector decoder; only FETCH and MEMWR
// look at mem_ready, only BRANCH looks at the opcode.
module mips_ctrl_decode
   import mips_ctrl_pkg::*;
#(
   parameter int              OP_W   = 6,
   parameter logic [OP_W-1:0] OP_BNE = OP_W'(OPC_BNE),
   parameter bit              EN_BNE = 1'b1
) (
   input  state_t          state,
   input  logic [OP_W-1:0] op,
   input  logic            mem_ready,
   output ctrl_t           ctrl
);

   always_comb begin
      ctrl = '0;
      unique case (state)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.aluop     = ALU_ADD;
            ctrl.pc_source = PCSRC_ALU;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         S_DECODE: begin
            ctrl.alu_src_b = SRCB_IMMSH;
            ctrl.aluop     = ALU_ADD;
         end
         S_MEMADR, S_IEXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.aluop     = ALU_ADD;
         end
         S_MEMRD: begin
            ctrl.mem_read = 1'b1;
            ctrl.iord     = 1'b1;
         end
         S_MEMWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.memto_reg  = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         S_MEMWR: begin
            ctrl.mem_write  = 1'b1;
            ctrl.iord       = 1'b1;
            ctrl.instr_done = mem_ready;
         end
         S_REXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REG;
            ctrl.aluop     = ALU_FUNCT;
         end
         S_RWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = SRCB_REG;
            ctrl.aluop         = ALU_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCSRC_ALUOUT;
            ctrl.branch_ne     = EN_BNE && (op == OP_BNE);
            ctrl.instr_done    = 1'b1;
         end
         S_JUMP: begin
            ctrl.pc_write   = 1'b1;
            ctrl.pc_source  = PCSRC_JUMP;
            ctrl.instr_done = 1'b1;
         end
         S_IWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM: state register, next-state
// logic and sticky illegal-opcode flag around the decoder.
module mips_multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter int              OP_W     = 6,
   parameter logic [OP_W-1:0] OP_RTYPE = OP_W'(OPC_RTYPE),
   parameter logic [OP_W-1:0] OP_LW    = OP_W'(OPC_LW),
   parameter logic [OP_W-1:0] OP_SW    = OP_W'(OPC_SW),
   parameter logic [OP_W-1:0] OP_BEQ   = OP_W'(OPC_BEQ),
   parameter logic [OP_W-1:0] OP_BNE   = OP_W'(OPC_BNE),
   parameter logic [OP_W-1:0] OP_J     = OP_W'(OPC_J),
   parameter logic [OP_W-1:0] OP_ADDI  = OP_W'(OPC_ADDI),
   parameter bit              EN_BNE   = 1'b1,
   parameter bit              EN_ADDI  = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [OP_W-1:0] op,
   input  logic            mem_ready,
   output logic            PCWrite,
   output logic            PCWriteCond,
   output logic            BranchNe,
   output logic            IorD,
   output logic            MemRead,
   output logic            MemWrite,
   output logic            IRWrite,
   output logic            MemtoReg,
   output logic            RegDst,
   output logic            RegWrite,
   output logic            AluSrcA,
   output logic [1:0]      AluSrcB,
   output logic [1:0]      Aluop,
   output logic [1:0]      PCSource,
   output logic            instr_done,
   output logic            illegal,
   output logic [3:0]      state_o
);

   state_t state, next;
   logic   illegal_q;
   ctrl_t  ctrl;

   logic is_r, is_mem, is_br, is_j, is_addi;

   assign is_r    = (op == OP_RTYPE);
   assign is_mem  = (op == OP_LW) || (op == OP_SW);
   assign is_br   = (op == OP_BEQ) || (EN_BNE && (op == OP_BNE));
   assign is_j    = (op == OP_J);
   assign is_addi = EN_ADDI && (op == OP_ADDI);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         illegal_q <= 1'b0;
      end else begin
         state <= next;
         if (next == S_TRAP)
            illegal_q <= 1'b1;
      end
   end

   always_comb begin
      next = state;
      unique case (state)
         S_IDLE:   next = S_FETCH;
         S_FETCH:  next = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            unique case (1'b1)
               is_mem:  next = S_MEMADR;
               is_r:    next = S_REXEC;
               is_br:   next = S_BRANCH;
               is_j:    next = S_JUMP;
               is_addi: next = S_IEXEC;
               default: next = S_TRAP;
            endcase
         end
         // Opcode is looked at again here, so the IR must hold.
         S_MEMADR: next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  next = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR:  next = mem_ready ? S_FETCH : S_MEMWR;
         S_REXEC:  next = S_RWB;
         S_IEXEC:  next = S_IWB;
         S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_IWB:
                   next = S_FETCH;
         S_TRAP:   next = S_TRAP;
         default:  next = S_IDLE;
      endcase
   end

   mips_ctrl_decode #(
      .OP_W   (OP_W),
      .OP_BNE (OP_BNE),
      .EN_BNE (EN_BNE)
   ) u_decode (
      .state     (state),
      .op        (op),
      .mem_ready (mem_ready),
      .ctrl      (ctrl)
   );

   assign PCWrite     = ctrl.pc_write;
   assign PCWriteCond = ctrl.pc_write_cond;
   assign BranchNe    = ctrl.branch_ne;
   assign IorD        = ctrl.iord;
   assign MemRead     = ctrl.mem_read;
   assign MemWrite    = ctrl.mem_write;
   assign IRWrite     = ctrl.ir_write;
   assign MemtoReg    = ctrl.memto_reg;
   assign RegDst      = ctrl.reg_dst;
   assign RegWrite    = ctrl.reg_write;
   assign AluSrcA     = ctrl.alu_src_a;
   assign AluSrcB     = ctrl.alu_src_b;
   assign Aluop       = ctrl.aluop;
   assign PCSource    = ctrl.pc_source;
   assign instr_done  = ctrl.instr_done;
   assign illegal     = illegal_q;
   assign state_o     = state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench: per-cycle expected controls from an
// instruction-level step model, checked by negedge monitors.
module tb_mips_multicycle_control;

   typedef struct packed {
      logic       pcw, pcwc, bne, iord, mr, mw, irw;
      logic       m2r, rdst, rw, asa;
      logic [1:0] asb, aop, pcs;
      logic       done, ill;
      logic [3:0] st;
   } obs_t;

   typedef enum {
      K_IDLE, K_FETCH, K_DECODE, K_MEMADR, K_MEMRD,
      K_MEMWB, K_MEMWR, K_REXEC, K_RWB, K_BRANCH,
      K_JUMP, K_IEXEC, K_IWB, K_TRAP
   } step_t;

   logic       clk = 1'b0;
   logic       rst_n, rst2_n, mem_ready, rdy2;
   logic [5:0] op, op2, cur_op;

   logic       a_pcw, a_pcwc, a_bne, a_iord, a_mr, a_mw, a_irw;
   logic       a_m2r, a_rdst, a_rw, a_asa, a_done, a_ill;
   logic [1:0] a_asb, a_aop, a_pcs;
   logic [3:0] a_st;
   logic       b_pcw, b_pcwc, b_bne, b_iord, b_mr, b_mw, b_irw;
   logic       b_m2r, b_rdst, b_rw, b_asa, b_done, b_ill;
   logic [1:0] b_asb, b_aop, b_pcs;
   logic [3:0] b_st;
   obs_t       a_obs, b_obs, ea, eb;

   obs_t  q1[$], q2[$];
   string n1[$], n2[$];
   string na, nb;
   int    checks = 0;
   int    errors = 0;

   always #5 clk = ~clk;

   assign a_obs = {a_pcw, a_pcwc, a_bne, a_iord, a_mr, a_mw,
                   a_irw, a_m2r, a_rdst, a_rw, a_asa, a_asb,
                   a_aop, a_pcs, a_done, a_ill, a_st};
   assign b_obs = {b_pcw, b_pcwc, b_bne, b_iord, b_mr, b_mw,
                   b_irw, b_m2r, b_rdst, b_rw, b_asa, b_asb,
                   b_aop, b_pcs, b_done, b_ill, b_st};

   mips_multicycle_control #(.EN_BNE(1'b1), .EN_ADDI(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
      .PCWrite(a_pcw), .PCWriteCond(a_pcwc), .BranchNe(a_bne),
      .IorD(a_iord), .MemRead(a_mr), .MemWrite(a_mw),
      .IRWrite(a_irw), .MemtoReg(a_m2r), .RegDst(a_rdst),
      .RegWrite(a_rw), .AluSrcA(a_asa), .AluSrcB(a_asb),
      .Aluop(a_aop), .PCSource(a_pcs), .instr_done(a_done),
      .illegal(a_ill), .state_o(a_st)
   );

   mips_multicycle_control #(.EN_BNE(1'b0), .EN_ADDI(1'b1)) dut_nobne (
      .clk(clk), .rst_n(rst2_n), .op(op2), .mem_ready(rdy2),
      .PCWrite(b_pcw), .PCWriteCond(b_pcwc), .BranchNe(b_bne),
      .IorD(b_iord), .MemRead(b_mr), .MemWrite(b_mw),
      .IRWrite(b_irw), .MemtoReg(b_m2r), .RegDst(b_rdst),
      .RegWrite(b_rw), .AluSrcA(b_asa), .AluSrcB(b_asb),
      .Aluop(b_aop), .PCSource(b_pcs), .instr_done(b_done),
      .illegal(b_ill), .state_o(b_st)
   );

   // Expected outputs for one cycle spent in a given step.
   function automatic obs_t model(step_t s, logic [5:0] o,
                                  logic r, bit en_bne);
      obs_t e = '0;
      case (s)
         K_FETCH:  begin e.mr = 1; e.asb = 1; e.irw = r;
                         e.pcw = r; e.st = 1; end
         K_DECODE: begin e.asb = 3; e.st = 2; end
         K_MEMADR: begin e.asa = 1; e.asb = 2; e.st = 3; end
         K_MEMRD:  begin e.mr = 1; e.iord = 1; e.st = 4; end
         K_MEMWB:  begin e.rw = 1; e.m2r = 1; e.done = 1;
                         e.st = 5; end
         K_MEMWR:  begin e.mw = 1; e.iord = 1; e.done = r;
                         e.st = 6; end
         K_REXEC:  begin e.asa = 1; e.aop = 2; e.st = 7; end
         K_RWB:    begin e.rw = 1; e.rdst = 1; e.done = 1;
                         e.st = 8; end
         K_BRANCH: begin e.asa = 1; e.aop = 1; e.pcwc = 1;
                         e.pcs = 1; e.done = 1; e.st = 9;
                         e.bne = en_bne && (o == 6'h05); end
         K_JUMP:   begin e.pcw = 1; e.pcs = 2; e.done = 1;
                         e.st = 10; end
         K_IEXEC:  begin e.asa = 1; e.asb = 2; e.st = 11; end
         K_IWB:    begin e.rw = 1; e.done = 1; e.st = 12; end
         K_TRAP:   begin e.ill = 1; e.st = 13; end
         default:  e = '0;
      endcase
      return e;
   endfunction

   function automatic logic rb();
      return 1'($urandom);
   endfunction

   task automatic step(input bit d2, input step_t s,
                       input logic r, input logic rs);
      @(posedge clk);
      #1;
      if (d2) begin
         rst2_n = rs; op2 = cur_op; rdy2 = r;
         q2.push_back(rs ? model(s, cur_op, r, 1'b0) : '0);
         n2.push_back(s.name());
      end else begin
         rst_n = rs; op = cur_op; mem_ready = r;
         q1.push_back(rs ? model(s, cur_op, r, 1'b1) : '0);
         n1.push_back(s.name());
      end
   endtask

   task automatic instr(input bit d2, input logic [5:0] o,
                        input int fw, input int mw);
      step_t ms;
      cur_op = o;
      repeat (fw) step(d2, K_FETCH, 1'b0, 1'b1);
      step(d2, K_FETCH, 1'b1, 1'b1);
      step(d2, K_DECODE, rb(), 1'b1);
      if (o == 6'h00) begin
         step(d2, K_REXEC, rb(), 1'b1);
         step(d2, K_RWB, rb(), 1'b1);
      end else if (o == 6'h23 || o == 6'h2B) begin
         ms = (o == 6'h23) ? K_MEMRD : K_MEMWR;
         step(d2, K_MEMADR, rb(), 1'b1);
         repeat (mw) step(d2, ms, 1'b0, 1'b1);
         step(d2, ms, 1'b1, 1'b1);
         if (o == 6'h23) step(d2, K_MEMWB, rb(), 1'b1);
      end else if (o == 6'h04 || (o == 6'h05 && !d2)) begin
         step(d2, K_BRANCH, rb(), 1'b1);
      end else if (o == 6'h02) begin
         step(d2, K_JUMP, rb(), 1'b1);
      end else if (o == 6'h08) begin
         step(d2, K_IEXEC, rb(), 1'b1);
         step(d2, K_IWB, rb(), 1'b1);
      end else begin
         repeat (10) step(d2, K_TRAP, rb(), 1'b1);
      end
   endtask

   always @(negedge clk) begin
      if (q1.size() > 0) begin
         ea = q1.pop_front();
         na = n1.pop_front();
         checks++;
         if (a_obs !== ea) begin
            errors++;
            $display("FAIL dut %s: got %h expected %h", na, a_obs, ea);
         end
      end
      if (q2.size() > 0) begin
         eb = q2.pop_front();
         nb = n2.pop_front();
         checks++;
         if (b_obs !== eb) begin
            errors++;
            $display("FAIL nobne %s: got %h expected %h", nb, b_obs, eb);
         end
      end
      if (a_mr && a_mw) begin
         errors++;
         $display("FAIL memrw_excl: MemRead=%b MemWrite=%b want not both",
                  a_mr, a_mw);
      end
   end

   logic [5:0] ops [7];

   initial begin
      ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08};
      rst_n = 1'b0; rst2_n = 1'b0;
      mem_ready = 1'b0; rdy2 = 1'b0;
      op = 6'h00; op2 = 6'h00; cur_op = 6'h00;

      repeat (3) step(1'b0, K_IDLE, 1'b0, 1'b0);
      step(1'b0, K_IDLE, 1'b1, 1'b1);
      instr(1'b0, 6'h00, 0, 0);
      instr(1'b0, 6'h23, 0, 2);
      instr(1'b0, 6'h2B, 0, 0);
      instr(1'b0, 6'h05, 0, 0);
      instr(1'b0, 6'h04, 1, 0);
      instr(1'b0, 6'h02, 0, 0);

      // lw aborted by reset while waiting in MEMRD.
      cur_op = 6'h23;
      step(1'b0, K_FETCH, 1'b1, 1'b1);
      step(1'b0, K_DECODE, 1'b1, 1'b1);
      step(1'b0, K_MEMADR, 1'b1, 1'b1);
      step(1'b0, K_MEMRD, 1'b0, 1'b1);
      step(1'b0, K_IDLE, 1'b1, 1'b0);
      step(1'b0, K_IDLE, 1'b1, 1'b0);
      step(1'b0, K_IDLE, 1'b1, 1'b1);

      instr(1'b0, 6'h08, 3, 0);
      for (int i = 0; i < 150; i++)
         instr(1'b0, ops[$urandom_range(0, 6)],
               $urandom_range(0, 2), $urandom_range(0, 3));
      instr(1'b0, 6'h3F, 0, 0);

      cur_op = 6'h05;
      step(1'b1, K_IDLE, 1'b1, 1'b1);
      instr(1'b1, 6'h05, 0, 0);

      repeat (2) @(negedge clk);
      checks++;
      if (q1.size() != 0 || q2.size() != 0) begin
         errors++;
         $display("FAIL drain: pending %0d/%0d expected 0",
                  q1.size(), q2.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
